// File: rtl/ram_pkg.sv
// Shared constants and helpers for the byte-enabled
// true dual-port RAM family.
package ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   function automatic int nbytes(
      input int data_width,
      input int byte_width
   );
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/ram_tdp_be_if.sv
// One RAM access port: request side driven by the master,
// read return driven by the RAM.
interface ram_tdp_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   import ram_pkg::*;

   localparam int NB = nbytes(DATA_WIDTH, BYTE_WIDTH);

   logic                  cs;
   logic                  we;
   logic [NB-1:0]         be;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;

   modport master (
      output cs, we, be, address, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  cs, we, be, address, wdata,
      output rdata, rvalid
   );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read return pipeline: RD_LATENCY data/valid stages,
// data registers hold when no read passes through.
module ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [RD_LATENCY-1:0] v;
   logic [DATA_WIDTH-1:0] d [RD_LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
         for (int i = 0; i < RD_LATENCY; i++)
            d[i] <= '0;
      end else begin
         v[0] <= in_valid;
         if (in_valid)
            d[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            v[i] <= v[i-1];
            if (v[i-1])
               d[i] <= d[i-1];
         end
      end
   end

   assign out_valid = v[RD_LATENCY-1];
   assign out_data  = d[RD_LATENCY-1];

endmodule

// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte enables, read-during-write
// modes, write-write arbitration and a collision flag.
module ram_tdp_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0,
   parameter int PORT0_PRIO = 1
) (
   input  logic         clk,
   input  logic         rst,
   ram_tdp_be_if.slave  p0,
   ram_tdp_be_if.slave  p1,
   output logic         collision
);

   localparam int NB = nbytes(DATA_WIDTH, BYTE_WIDTH);
   localparam int LO = (PORT0_PRIO != 0) ? 1 : 0;
   localparam int HI = 1 - LO;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 ||
       (RD_LATENCY != 1 && RD_LATENCY != 2)) begin : g_bad_cfg
      $error("ram_tdp_be: bad width or latency parameters");
   end

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic [1:0]            cs;
   logic [1:0]            we;
   logic [NB-1:0]         be    [2];
   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [DATA_WIDTH-1:0] wd    [2];
   logic [DATA_WIDTH-1:0] old   [2];
   logic [DATA_WIDTH-1:0] rd_in [2];
   logic [DATA_WIDTH-1:0] rdq   [2];
   logic [1:0]            inr;
   logic [1:0]            wr;
   logic [1:0]            rd_go;
   logic [1:0]            rv;
   logic                  coll_c;

   assign cs      = {p1.cs, p0.cs};
   assign we      = {p1.we, p0.we};
   assign be[0]   = p0.be;
   assign be[1]   = p1.be;
   assign addr[0] = p0.address;
   assign addr[1] = p1.address;
   assign wd[0]   = p0.wdata;
   assign wd[1]   = p1.wdata;

   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [DATA_WIDTH-1:0] base,
      input logic [DATA_WIDTH-1:0] upd,
      input logic [NB-1:0]         en
   );
      logic [DATA_WIDTH-1:0] r;
      r = base;
      for (int b = 0; b < NB; b++)
         if (en[b])
            r[b*BYTE_WIDTH +: BYTE_WIDTH] =
               upd[b*BYTE_WIDTH +: BYTE_WIDTH];
      return r;
   endfunction

   // Reads always see the pre-edge word, so cross-port
   // accesses behave read-first.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         inr[n]   = int'(addr[n]) < RAM_DEPTH;
         old[n]   = inr[n] ? mem[addr[n]] : '0;
         wr[n]    = !rst && cs[n] && we[n] && (|be[n]);
         rd_go[n] = !rst && cs[n] &&
                    (!we[n] || RDW_MODE != RDW_NO_CHANGE);
         rd_in[n] = old[n];
         if (we[n] && inr[n] && RDW_MODE == RDW_WRITE_FIRST)
            rd_in[n] = merge(old[n], wd[n], be[n]);
      end
      coll_c = cs[0] && cs[1] && (addr[0] == addr[1]) &&
               (wr[0] || wr[1]);
   end

   // Higher-priority port is written last so its bytes win.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (wr[LO] && inr[LO] && be[LO][b])
            mem[addr[LO]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
               wd[LO][b*BYTE_WIDTH +: BYTE_WIDTH];
         if (wr[HI] && inr[HI] && be[HI][b])
            mem[addr[HI]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
               wd[HI][b*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         collision <= 1'b0;
      else
         collision <= coll_c;
   end

   ram_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .RD_LATENCY(RD_LATENCY)
   ) u_pipe0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_go[0]),
      .in_data   (rd_in[0]),
      .out_valid (rv[0]),
      .out_data  (rdq[0])
   );

   ram_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .RD_LATENCY(RD_LATENCY)
   ) u_pipe1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_go[1]),
      .in_data   (rd_in[1]),
      .out_valid (rv[1]),
      .out_data  (rdq[1])
   );

   assign p0.rvalid = rv[0];
   assign p0.rdata  = rdq[0];
   assign p1.rvalid = rv[1];
   assign p1.rdata  = rdq[1];

endmodule

// File: tb/tb_ram_tdp_be.sv
// Directed bench for ram_tdp_be: three instances cover
// READ_FIRST/lat1, WRITE_FIRST/lat1 and NO_CHANGE/lat2/port1-prio.
module tb_ram_tdp_be;

   logic clk;
   logic rst;
   logic coll_a, coll_b, coll_c;
   int   errors;
   int   checks;

   ram_tdp_be_if a0 ();
   ram_tdp_be_if a1 ();
   ram_tdp_be_if b0 ();
   ram_tdp_be_if b1 ();
   ram_tdp_be_if c0 ();
   ram_tdp_be_if c1 ();

   ram_tdp_be u_a (
      .clk(clk), .rst(rst), .p0(a0), .p1(a1), .collision(coll_a)
   );

   ram_tdp_be #(.RDW_MODE(1)) u_b (
      .clk(clk), .rst(rst), .p0(b0), .p1(b1), .collision(coll_b)
   );

   ram_tdp_be #(
      .RDW_MODE(2), .RD_LATENCY(2), .PORT0_PRIO(0)
   ) u_c (
      .clk(clk), .rst(rst), .p0(c0), .p1(c1), .collision(coll_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      a0.cs = 0; a0.we = 0; a0.be = 0; a0.address = 0; a0.wdata = 0;
      a1.cs = 0; a1.we = 0; a1.be = 0; a1.address = 0; a1.wdata = 0;
      b0.cs = 0; b0.we = 0; b0.be = 0; b0.address = 0; b0.wdata = 0;
      b1.cs = 0; b1.we = 0; b1.be = 0; b1.address = 0; b1.wdata = 0;
      c0.cs = 0; c0.we = 0; c0.be = 0; c0.address = 0; c0.wdata = 0;
      c1.cs = 0; c1.we = 0; c1.be = 0; c1.address = 0; c1.wdata = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      checks++;
      if (a0.rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_a0_rdata: got %h want 0", a0.rdata);
      end
      checks++;
      if (a1.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_a1_rvalid: got %b want 0", a1.rvalid);
      end
      checks++;
      if (coll_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_coll: got %b want 0", coll_a);
      end
      checks++;
      if (c0.rdata !== 32'h0 || c1.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_c: got %h/%b want 0/0", c0.rdata, c1.rvalid);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      a0.cs = 1; a0.we = 1; a0.be = 4'hF;
      a0.address = 8'h05; a0.wdata = 32'h11223344;
      tick();
      idle();
      a1.cs = 1; a1.address = 8'h05;
      tick();
      idle();
      checks++;
      if (a1.rvalid !== 1'b1) begin
         errors++;
         $display("FAIL basic_rvalid: got %b want 1", a1.rvalid);
      end
      checks++;
      if (a1.rdata !== 32'h11223344) begin
         errors++;
         $display("FAIL basic_rdata: got %h want 11223344", a1.rdata);
      end
      tick();
      checks++;
      if (a1.rvalid !== 1'b0 || a1.rdata !== 32'h11223344) begin
         errors++;
         $display("FAIL basic_hold: got %b/%h want 0/11223344",
                  a1.rvalid, a1.rdata);
      end
   endtask

   task automatic test_byte_en();
      a0.cs = 1; a0.we = 1; a0.be = 4'hF;
      a0.address = 8'h10; a0.wdata = 32'hAABBCCDD;
      tick();
      a0.be = 4'h1; a0.wdata = 32'h00000055;
      tick();
      checks++;
      if (a0.rvalid !== 1'b1 || a0.rdata !== 32'hAABBCCDD) begin
         errors++;
         $display("FAIL rdw_read_first: got %b/%h want 1/aabbccdd",
                  a0.rvalid, a0.rdata);
      end
      a0.we = 0; a0.be = 0;
      tick();
      idle();
      checks++;
      if (a0.rdata !== 32'hAABBCC55) begin
         errors++;
         $display("FAIL byte_en: got %h want aabbcc55", a0.rdata);
      end
   endtask

   task automatic test_dual_write();
      a0.cs = 1; a0.we = 1; a0.be = 4'hF; a0.address = 8'h20;
      c0.cs = 1; c0.we = 1; c0.be = 4'hF; c0.address = 8'h20;
      a0.wdata = 0; c0.wdata = 0;
      tick();
      a0.be = 4'h3; a0.wdata = 32'h11111111;
      c0.be = 4'h3; c0.wdata = 32'h11111111;
      a1.cs = 1; a1.we = 1; a1.be = 4'h6;
      a1.address = 8'h20; a1.wdata = 32'h22222222;
      c1.cs = 1; c1.we = 1; c1.be = 4'h6;
      c1.address = 8'h20; c1.wdata = 32'h22222222;
      tick();
      idle();
      checks++;
      if (coll_a !== 1'b1 || coll_c !== 1'b1) begin
         errors++;
         $display("FAIL ww_coll: got %b/%b want 1/1", coll_a, coll_c);
      end
      a0.cs = 1; a0.address = 8'h20;
      c0.cs = 1; c0.address = 8'h20;
      tick();
      idle();
      checks++;
      if (coll_a !== 1'b0) begin
         errors++;
         $display("FAIL ww_coll_pulse: got %b want 0", coll_a);
      end
      checks++;
      if (a0.rdata !== 32'h00221111) begin
         errors++;
         $display("FAIL ww_p0prio: got %h want 00221111", a0.rdata);
      end
      tick();
      checks++;
      if (c0.rvalid !== 1'b1 || c0.rdata !== 32'h00222211) begin
         errors++;
         $display("FAIL ww_p1prio: got %b/%h want 1/00222211",
                  c0.rvalid, c0.rdata);
      end
      a0.cs = 1; a0.we = 1; a0.be = 4'h0; a0.address = 8'h20;
      a1.cs = 1; a1.address = 8'h20;
      tick();
      idle();
      checks++;
      if (coll_a !== 1'b0) begin
         errors++;
         $display("FAIL be0_no_coll: got %b want 0", coll_a);
      end
   endtask

   task automatic test_cross_rw();
      a0.cs = 1; a0.we = 1; a0.be = 4'hF;
      a0.address = 8'h30; a0.wdata = 32'h00000001;
      tick();
      a0.wdata = 32'h5A5A5A5A;
      a1.cs = 1; a1.address = 8'h30;
      tick();
      idle();
      checks++;
      if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h00000001) begin
         errors++;
         $display("FAIL wr_rd_old: got %b/%h want 1/00000001",
                  a1.rvalid, a1.rdata);
      end
      checks++;
      if (coll_a !== 1'b1) begin
         errors++;
         $display("FAIL wr_rd_coll: got %b want 1", coll_a);
      end
      a1.cs = 1; a1.address = 8'h30;
      tick();
      idle();
      checks++;
      if (a1.rdata !== 32'h5A5A5A5A || coll_a !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_new: got %h/%b want 5a5a5a5a/0",
                  a1.rdata, coll_a);
      end
   endtask

   task automatic test_rdw_modes();
      b0.cs = 1; b0.we = 1; b0.be = 4'hF;
      b0.address = 8'h31; b0.wdata = 32'h00000001;
      tick();
      b0.be = 4'h2; b0.wdata = 32'h0000AB00;
      tick();
      idle();
      checks++;
      if (b0.rvalid !== 1'b1 || b0.rdata !== 32'h0000AB01) begin
         errors++;
         $display("FAIL rdw_write_first: got %b/%h want 1/0000ab01",
                  b0.rvalid, b0.rdata);
      end
      c0.cs = 1; c0.we = 1; c0.be = 4'hF;
      c0.address = 8'h31; c0.wdata = 32'h00000077;
      tick();
      c0.we = 0; c0.be = 0;
      tick();
      idle();
      tick();
      checks++;
      if (c0.rvalid !== 1'b1 || c0.rdata !== 32'h00000077) begin
         errors++;
         $display("FAIL nc_prime: got %b/%h want 1/00000077",
                  c0.rvalid, c0.rdata);
      end
      c0.cs = 1; c0.we = 1; c0.be = 4'hF;
      c0.address = 8'h31; c0.wdata = 32'h00000088;
      tick();
      idle();
      checks++;
      if (c0.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL nc_rvalid0: got %b want 0", c0.rvalid);
      end
      tick();
      checks++;
      if (c0.rvalid !== 1'b0 || c0.rdata !== 32'h00000077) begin
         errors++;
         $display("FAIL nc_held: got %b/%h want 0/00000077",
                  c0.rvalid, c0.rdata);
      end
      c0.cs = 1; c0.address = 8'h31;
      tick();
      idle();
      tick();
      checks++;
      if (c0.rdata !== 32'h00000088) begin
         errors++;
         $display("FAIL nc_written: got %h want 00000088", c0.rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      logic [31:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         c0.cs = 1; c0.we = 1; c0.be = 4'hF;
         c0.address = 8'(i); c0.wdata = 32'hC0DE0000 + 32'(i);
         tick();
      end
      idle();
      tick();
      tick();
      for (int i = 0; i < 7; i++) begin
         exp_v = (i >= 2 && i <= 5);
         exp_d = 32'hC0DE0000 + 32'(i - 2);
         checks++;
         if (c0.rvalid !== exp_v) begin
            errors++;
            $display("FAIL b2b_rvalid[%0d]: got %b want %b",
                     i, c0.rvalid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (c0.rdata !== exp_d) begin
               errors++;
               $display("FAIL b2b_rdata[%0d]: got %h want %h",
                        i, c0.rdata, exp_d);
            end
         end
         if (i < 4) begin
            c0.cs = 1; c0.we = 0; c0.address = 8'(i);
         end else begin
            idle();
         end
         tick();
      end
   endtask

   task automatic test_rst_inflight();
      a0.cs = 1; a0.we = 1; a0.be = 4'hF;
      a0.address = 8'h40; a0.wdata = 32'h12345678;
      c0.cs = 1; c0.we = 1; c0.be = 4'hF;
      c0.address = 8'h40; c0.wdata = 32'h12345678;
      tick();
      idle();
      c1.cs = 1; c1.address = 8'h40;
      tick();
      rst = 1;
      a0.cs = 1; a0.we = 1; a0.be = 4'hF;
      a0.address = 8'h40; a0.wdata = 32'hDEADBEEF;
      c0.cs = 1; c0.we = 1; c0.be = 4'hF;
      c0.address = 8'h40; c0.wdata = 32'hDEADBEEF;
      a1.cs = 1; a1.address = 8'h40;
      tick();
      checks++;
      if (c1.rvalid !== 1'b0 || c1.rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_inflight_c: got %b/%h want 0/0",
                  c1.rvalid, c1.rdata);
      end
      checks++;
      if (a1.rvalid !== 1'b0 || a1.rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_read_a: got %b/%h want 0/0",
                  a1.rvalid, a1.rdata);
      end
      tick();
      checks++;
      if (c1.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_inflight_c2: got %b want 0", c1.rvalid);
      end
      rst = 0;
      idle();
      a1.cs = 1; a1.address = 8'h40;
      c1.cs = 1; c1.address = 8'h40;
      tick();
      idle();
      checks++;
      if (a1.rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL rst_no_write_a: got %h want 12345678", a1.rdata);
      end
      tick();
      checks++;
      if (c1.rvalid !== 1'b1 || c1.rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL rst_no_write_c: got %b/%h want 1/12345678",
                  c1.rvalid, c1.rdata);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1;
      idle();
      test_reset();
      test_basic();
      test_byte_en();
      test_dual_write();
      test_cross_rw();
      test_rdw_modes();
      test_back_to_back();
      test_rst_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
